// File: rtl/fc.sv
// Flow-control unit: redirect priority, flushes, load-use bubbles and dcache miss freeze.
// Optional performance counters are built when FC_PERF_CNT_EN is defined.
module fc #(
  parameter int unsigned DC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_branch_taken_i,
  input  logic [31:0] ex_branch_target_i,
  input  logic        id_jump_i,
  input  logic [31:0] id_jump_target_i,
  input  logic        id_load_use_i,
  input  logic        mem_dc_req_i,
  input  logic        dc_ready_i,
  output logic        fc_flush_btype_flag_o,
  output logic        fc_flush_jtype_flag_o,
  output logic        fc_jump_flag_o,
  output logic [31:0] fc_jump_addr_o,
  output logic        fc_stall_if_o,
  output logic        fc_stall_id_o,
  output logic        fc_stall_ex_o,
  output logic        fc_stall_mem_o,
  output logic        fc_bubble_ex_o,
`ifdef FC_PERF_CNT_EN
  output logic [31:0] fc_perf_stall_cnt_o,
  output logic [31:0] fc_perf_flush_cnt_o,
`endif
  output logic        fc_dc_timeout_o
);

  typedef enum logic {
    RUN,
    DC_WAIT
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(DC_TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        timeout_reg, timeout_next;

  logic        miss;
  logic        mem_stall;
  logic        btype;
  logic        jtype;
  logic        load_use;
  logic [31:0] jump_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      cnt_reg     <= 16'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    miss         = mem_dc_req_i & ~dc_ready_i;
    mem_stall    = 1'b0;

    case (state_reg)
      RUN: begin
        if (miss) begin
          mem_stall  = 1'b1;
          state_next = DC_WAIT;
          cnt_next   = 16'd0;
        end
      end
      DC_WAIT: begin
        mem_stall = ~dc_ready_i;
        cnt_next  = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
        // The flag is sticky; stalling carries on past the limit.
        if (cnt_next >= TIMEOUT_CNT) begin
          timeout_next = 1'b1;
        end
        if (dc_ready_i) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // EX holds the older instruction, so a taken branch wins over an ID jump
  // and also discards any load-use dependent instruction sitting in ID.
  always_comb begin
    btype     = 1'b0;
    jtype     = 1'b0;
    load_use  = 1'b0;
    jump_addr = 32'd0;
    if (!mem_stall) begin
      if (ex_branch_taken_i) begin
        btype     = 1'b1;
        jump_addr = ex_branch_target_i;
      end else if (id_load_use_i) begin
        load_use = 1'b1;
      end else if (id_jump_i) begin
        jtype     = 1'b1;
        jump_addr = id_jump_target_i;
      end
    end
  end

  // Gating with rst_n keeps every output at 0 while reset is held.
  always_comb begin
    fc_flush_btype_flag_o = rst_n & btype;
    fc_flush_jtype_flag_o = rst_n & jtype;
    fc_jump_flag_o        = rst_n & (btype | jtype);
    fc_jump_addr_o        = rst_n ? jump_addr : 32'd0;
    fc_stall_if_o         = rst_n & (mem_stall | load_use);
    fc_stall_id_o         = rst_n & (mem_stall | load_use);
    fc_stall_ex_o         = rst_n & mem_stall;
    fc_stall_mem_o        = rst_n & mem_stall;
    fc_bubble_ex_o        = rst_n & load_use;
    fc_dc_timeout_o       = timeout_reg;
  end

`ifdef FC_PERF_CNT_EN
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_reg <= 32'd0;
      perf_flush_reg <= 32'd0;
    end else begin
      perf_stall_reg <= perf_stall_reg + 32'(mem_stall);
      perf_flush_reg <= perf_flush_reg + 32'(btype | jtype);
    end
  end

  assign fc_perf_stall_cnt_o = perf_stall_reg;
  assign fc_perf_flush_cnt_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_fc.sv
// Directed scoreboard bench for fc; expected outputs are queued per step and
// compared mid-cycle. Perf counter checks are compiled with FC_PERF_CNT_EN.
module tb_fc;

  logic        clk;
  logic        rst_n;
  logic        ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;
  logic        id_jump_i;
  logic [31:0] id_jump_target_i;
  logic        id_load_use_i;
  logic        mem_dc_req_i;
  logic        dc_ready_i;
  logic        fc_flush_btype_flag_o;
  logic        fc_flush_jtype_flag_o;
  logic        fc_jump_flag_o;
  logic [31:0] fc_jump_addr_o;
  logic        fc_stall_if_o;
  logic        fc_stall_id_o;
  logic        fc_stall_ex_o;
  logic        fc_stall_mem_o;
  logic        fc_bubble_ex_o;
  logic        fc_dc_timeout_o;
`ifdef FC_PERF_CNT_EN
  logic [31:0] fc_perf_stall_cnt_o;
  logic [31:0] fc_perf_flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        bt;
    logic        jt;
    logic        jf;
    logic [31:0] addr;
    logic [3:0]  stall;  // {if, id, ex, mem}
    logic        bub;
    logic        to;
  } exp_t;

  exp_t exp_q[$];

  fc #(.DC_TIMEOUT(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ex_branch_taken_i     (ex_branch_taken_i),
    .ex_branch_target_i    (ex_branch_target_i),
    .id_jump_i             (id_jump_i),
    .id_jump_target_i      (id_jump_target_i),
    .id_load_use_i         (id_load_use_i),
    .mem_dc_req_i          (mem_dc_req_i),
    .dc_ready_i            (dc_ready_i),
    .fc_flush_btype_flag_o (fc_flush_btype_flag_o),
    .fc_flush_jtype_flag_o (fc_flush_jtype_flag_o),
    .fc_jump_flag_o        (fc_jump_flag_o),
    .fc_jump_addr_o        (fc_jump_addr_o),
    .fc_stall_if_o         (fc_stall_if_o),
    .fc_stall_id_o         (fc_stall_id_o),
    .fc_stall_ex_o         (fc_stall_ex_o),
    .fc_stall_mem_o        (fc_stall_mem_o),
    .fc_bubble_ex_o        (fc_bubble_ex_o),
`ifdef FC_PERF_CNT_EN
    .fc_perf_stall_cnt_o   (fc_perf_stall_cnt_o),
    .fc_perf_flush_cnt_o   (fc_perf_flush_cnt_o),
`endif
    .fc_dc_timeout_o       (fc_dc_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic bt, input logic jt, input logic jf,
                              input logic [31:0] addr, input logic [3:0] stall,
                              input logic bub, input logic to);
    exp_t e;
    e.bt = bt; e.jt = jt; e.jf = jf; e.addr = addr;
    e.stall = stall; e.bub = bub; e.to = to;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs after the falling edge, queue the expectation,
  // then compare 2 time units later, well before the next rising edge.
  task automatic step(input string name, input logic rst, input logic bt,
                      input logic [31:0] bt_tgt, input logic jmp,
                      input logic [31:0] j_tgt, input logic lu, input logic req,
                      input logic rdy, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst_n              = rst;
    ex_branch_taken_i  = bt;
    ex_branch_target_i = bt_tgt;
    id_jump_i          = jmp;
    id_jump_target_i   = j_tgt;
    id_load_use_i      = lu;
    mem_dc_req_i       = req;
    dc_ready_i         = rdy;
    exp_q.push_back(e);
    #2;
    x = exp_q.pop_front();
    chk({name, ".btype"}, 32'(fc_flush_btype_flag_o), 32'(x.bt));
    chk({name, ".jtype"}, 32'(fc_flush_jtype_flag_o), 32'(x.jt));
    chk({name, ".jflag"}, 32'(fc_jump_flag_o), 32'(x.jf));
    chk({name, ".addr"}, fc_jump_addr_o, x.addr);
    chk({name, ".stall"}, 32'({fc_stall_if_o, fc_stall_id_o, fc_stall_ex_o, fc_stall_mem_o}),
        32'(x.stall));
    chk({name, ".bubble"}, 32'(fc_bubble_ex_o), 32'(x.bub));
    chk({name, ".timeout"}, 32'(fc_dc_timeout_o), 32'(x.to));
    $display("step %-10s bt=%0b jt=%0b jf=%0b addr=%h stall=%b bub=%0b to=%0b", name,
             fc_flush_btype_flag_o, fc_flush_jtype_flag_o, fc_jump_flag_o, fc_jump_addr_o,
             {fc_stall_if_o, fc_stall_id_o, fc_stall_ex_o, fc_stall_mem_o},
             fc_bubble_ex_o, fc_dc_timeout_o);
  endtask

  localparam logic [31:0] T1 = 32'h0000_0100;
  localparam logic [31:0] T2 = 32'h0000_0200;
  localparam logic [31:0] T3 = 32'h0000_0300;
  localparam logic [31:0] T4 = 32'h0000_0400;

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 32'd0, 4'b0000, 0, 0);
    rst_n = 1'b0;
    ex_branch_taken_i = 1'b0; ex_branch_target_i = 32'd0;
    id_jump_i = 1'b0; id_jump_target_i = 32'd0;
    id_load_use_i = 1'b0; mem_dc_req_i = 1'b0; dc_ready_i = 1'b0;

    // Reset: outputs held at 0 even with active inputs.
    step("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, z);
    step("rst_busy", 0, 1, T1, 1, T2, 1, 1, 0, z);

    // Redirect priority.
    step("br_vs_jmp", 1, 1, T1, 1, T2, 0, 0, 0, mk(1, 0, 1, T1, 4'b0000, 0, 0));
    step("jmp_only", 1, 0, T1, 1, T2, 0, 0, 0, mk(0, 1, 1, T2, 4'b0000, 0, 0));
    step("idle1", 1, 0, T1, 0, T2, 0, 0, 0, z);

    // 3-cycle miss with branch held taken; flush appears only on ready.
    step("miss_c1", 1, 1, T3, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("miss_c2", 1, 1, T3, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("miss_c3", 1, 1, T3, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("miss_rdy", 1, 1, T3, 0, 0, 0, 1, 1, mk(1, 0, 1, T3, 4'b0000, 0, 0));
    step("idle2", 1, 0, 0, 0, 0, 0, 0, 0, z);

    // Hit in RUN: no stall, no state change, redirect still evaluates.
    step("hit", 1, 0, 0, 1, T4, 0, 1, 1, mk(0, 1, 1, T4, 4'b0000, 0, 0));
    step("post_hit", 1, 0, 0, 0, 0, 0, 0, 0, z);

    // Load-use suppresses the jump; jump resolves the following cycle.
    step("lu_jmp", 1, 0, 0, 1, T4, 1, 0, 0, mk(0, 0, 0, 0, 4'b1100, 1, 0));
    step("jmp_after", 1, 0, 0, 1, T4, 0, 0, 0, mk(0, 1, 1, T4, 4'b0000, 0, 0));
    step("lu_br", 1, 1, T1, 0, 0, 1, 0, 0, mk(1, 0, 1, T1, 4'b0000, 0, 0));

    // Load-use masked during a memory stall, visible on the ready cycle.
    step("lu_miss", 1, 0, 0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("lu_wait", 1, 0, 0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("lu_rdy", 1, 0, 0, 0, 0, 1, 1, 1, mk(0, 0, 0, 0, 4'b1100, 1, 0));
    step("idle3", 1, 0, 0, 0, 0, 0, 0, 0, z);

    // Timeout with limit 4: request cycle, then flag visible from 5th wait cycle.
    step("to_req", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      step($sformatf("to_w%0d", i), 1, 0, 0, 0, 0, 0, 1, 0,
           mk(0, 0, 0, 0, 4'b1111, 0, (i >= 5) ? 1'b1 : 1'b0));
    end
    step("to_rdy", 1, 0, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0, 4'b0000, 0, 1));
    step("to_sticky", 1, 0, 0, 1, T2, 0, 0, 0, mk(0, 1, 1, T2, 4'b0000, 0, 1));
    step("to_rst", 0, 0, 0, 0, 0, 0, 0, 0, z);

    // Reset asserted mid-miss, then a fresh miss behaves normally.
    step("rm_req", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("rm_wait", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("rm_rst", 0, 1, T1, 0, 0, 0, 1, 0, z);
    step("rm_run", 1, 0, 0, 0, 0, 0, 0, 0, z);
    step("rm_miss", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("rm_wait2", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
    step("rm_rdy", 1, 0, 0, 0, 0, 0, 1, 1, z);
    step("rm_idle", 1, 0, 0, 0, 0, 0, 0, 0, z);

`ifdef FC_PERF_CNT_EN
    // Two 3-cycle misses plus one jump after a clean reset.
    step("pf_rst", 0, 0, 0, 0, 0, 0, 0, 0, z);
    chk("perf_stall_rst", fc_perf_stall_cnt_o, 32'd0);
    chk("perf_flush_rst", fc_perf_flush_cnt_o, 32'd0);
    for (int m = 0; m < 2; m++) begin
      step("pf_req", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
      step("pf_w1", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
      step("pf_w2", 1, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 4'b1111, 0, 0));
      step("pf_rdy", 1, 0, 0, 0, 0, 0, 1, 1, z);
    end
    step("pf_jmp", 1, 0, 0, 1, T4, 0, 0, 0, mk(0, 1, 1, T4, 4'b0000, 0, 0));
    step("pf_idle", 1, 0, 0, 0, 0, 0, 0, 0, z);
    chk("perf_stall", fc_perf_stall_cnt_o, 32'd6);
    chk("perf_flush", fc_perf_flush_cnt_o, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
